// File: rtl/syndrome_stream_driver_pkg.sv
// Shared definitions for the Helios host-side framer: protocol message bytes,
// the controller state encoding and small sizing helpers.
package syndrome_stream_driver_pkg;

  // Protocol message bytes understood by the decoder input FIFO.
  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef enum logic [2:0] {
    SEND_START,
    WAIT_FRAME,
    SEND_HDR,
    SEND_DATA,
    RECV,
    RESULT
  } state_t;

  // Integer ceiling division, used to size the beat count.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Frame width in bits: each round is padded to whole bytes.
  function automatic int frame_bits(input int x, input int z, input int u);
    return 8 * ((x * z + 7) >> 3) * u;
  endfunction

endpackage

// File: rtl/syndrome_stream_driver_frame_beat_serializer.sv
// Holds one captured measurement frame and slices it into STREAM_WIDTH beats,
// least significant byte first. The beat output already reflects the next
// index whenever advance is asserted, so the caller can register it directly.
module frame_beat_serializer
  import syndrome_stream_driver_pkg::*;
#(
  parameter int FW = 40,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [FW-1:0] frame_in,
  input  logic          advance,
  output logic [SW-1:0] beat,
  output logic          last
);

  localparam int BEATS = ceil_div(FW, SW);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = BEATS * SW;

  logic [FW-1:0] frame_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [PW-1:0] padded;

  // Capture the frame on acceptance and step the beat counter.
  // NOTE: the frame register is reset like any other state so a frame cut
  // short by reset can never leak into the next transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      cnt     <= '0;
    end else if (load) begin
      frame_q <= frame_in;
      cnt     <= '0;
    end else if (advance && !last) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last   = (cnt == CW'(BEATS - 1));
  assign idx    = cnt + CW'(advance & ~last);
  assign padded = PW'(frame_q);

  // Select the beat at idx; bytes past the end of the frame read as zero.
  // NOTE: beat gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (idx == CW'(b)) beat = padded[b*SW +: SW];
    end
  end

endmodule

// File: rtl/syndrome_stream_driver.sv
// Host-side framer for the Helios decoder byte protocol. Sends the start
// message once after reset, then a header plus frame beats per accepted
// frame, and parses the 3-byte reply into iteration and cycle counts.
// Optional statistics ports are built when SYNDROME_STREAM_STATS_EN is defined.
module syndrome_stream_driver
  import syndrome_stream_driver_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 5,
  parameter int STREAM_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [frame_bits(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U)-1:0] frame_data,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic [STREAM_WIDTH-1:0] tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              result_iterations,
  output logic [15:0]             result_cycles,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy
`ifdef SYNDROME_STREAM_STATS_EN
  ,
  output logic [31:0]             stat_frames,
  output logic [15:0]             stat_max_cycles
`endif
);

  localparam int FW = frame_bits(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
  localparam int SW = STREAM_WIDTH;

  state_t        state;
  state_t        state_next;
  logic          load_frame;
  logic          advance;
  logic          last;
  logic [SW-1:0] beat;
  logic          tx_set;
  logic          tx_drop;
  logic [SW-1:0] tx_next;
  logic [1:0]    rx_idx;
  logic          rx_fire;
  logic          result_fire;

  assign frame_ready = (state == WAIT_FRAME);
  assign rx_ready    = (state == RECV);
  assign load_frame  = frame_valid && frame_ready;
  assign advance     = (state == SEND_DATA) && tx_valid && tx_ready && !last;
  assign rx_fire     = rx_valid && rx_ready;
  assign result_fire = result_valid && result_ready;

  frame_beat_serializer #(
    .FW(FW),
    .SW(SW)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .load    (load_frame),
    .frame_in(frame_data),
    .advance (advance),
    .beat    (beat),
    .last    (last)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEND_START;
    else        state <= state_next;
  end

  // Next-state logic and the tx register load/drop requests.
  always_comb begin
    state_next = state;
    tx_set     = 1'b0;
    tx_drop    = 1'b0;
    tx_next    = '0;
    unique case (state)
      SEND_START: begin
        if (!tx_valid) begin
          tx_set  = 1'b1;
          tx_next = SW'(START_DECODING_MSG);
        end else if (tx_ready) begin
          tx_drop    = 1'b1;
          state_next = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_valid) begin
          tx_set     = 1'b1;
          tx_next    = SW'(MEASUREMENT_DATA_HEADER);
          state_next = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (tx_valid && tx_ready) begin
          tx_set     = 1'b1;
          tx_next    = beat;
          state_next = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (tx_valid && tx_ready) begin
          if (last) begin
            tx_drop    = 1'b1;
            state_next = RECV;
          end else begin
            tx_set  = 1'b1;
            tx_next = beat;
          end
        end
      end
      RECV: begin
        if (rx_fire && rx_idx == 2'd2) state_next = RESULT;
      end
      RESULT: begin
        if (result_ready) state_next = WAIT_FRAME;
      end
      default: state_next = SEND_START;
    endcase
  end

  // Registered tx beat: held unchanged while the FIFO stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (tx_set) begin
      tx_valid <= 1'b1;
      tx_data  <= tx_next;
    end else if (tx_drop) begin
      tx_valid <= 1'b0;
    end
  end

  // busy is registered so it reads 0 while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= 1'b0;
    else        busy <= (state_next != WAIT_FRAME);
  end

  // Assemble the 3-byte reply and hold the result until consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_idx            <= 2'd0;
      result_iterations <= 8'd0;
      result_cycles     <= 16'd0;
      result_valid      <= 1'b0;
    end else if (rx_fire) begin
      unique case (rx_idx)
        2'd0: begin
          result_iterations <= rx_data;
          rx_idx            <= 2'd1;
        end
        2'd1: begin
          result_cycles[15:8] <= rx_data;
          rx_idx              <= 2'd2;
        end
        default: begin
          result_cycles[7:0] <= rx_data;
          rx_idx             <= 2'd0;
          result_valid       <= 1'b1;
        end
      endcase
    end else if (result_fire) begin
      result_valid <= 1'b0;
    end
  end

`ifdef SYNDROME_STREAM_STATS_EN
  // Completed-decode counter (saturating) and peak cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_frames     <= 32'd0;
      stat_max_cycles <= 16'd0;
    end else if (result_fire) begin
      if (stat_frames != 32'hFFFF_FFFF) stat_frames <= stat_frames + 32'd1;
      if (result_cycles > stat_max_cycles) stat_max_cycles <= result_cycles;
    end
  end
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_syndrome_stream_driver.sv
// Directed bench for syndrome_stream_driver: one 8-bit and one 16-bit stream
// instance (X=4, Z=1, U=5 -> 5-byte frames) sharing clock and reset.
// Statistics checks are compiled when SYNDROME_STREAM_STATS_EN is defined.
module tb_syndrome_stream_driver;

  localparam logic [7:0] START_MSG = 8'h01;
  localparam logic [7:0] HDR_MSG   = 8'h02;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit stream instance signals
  logic [39:0] frame_data8;
  logic        frame_valid8, frame_ready8;
  logic [7:0]  tx_data8;
  logic        tx_valid8, tx_ready8;
  logic [7:0]  rx_data8;
  logic        rx_valid8, rx_ready8;
  logic [7:0]  res_it8;
  logic [15:0] res_cyc8;
  logic        res_valid8, res_ready8, busy8;

  // 16-bit stream instance signals
  logic [39:0] frame_data16;
  logic        frame_valid16, frame_ready16;
  logic [15:0] tx_data16;
  logic        tx_valid16, tx_ready16;
  logic [7:0]  rx_data16;
  logic        rx_valid16, rx_ready16;
  logic [7:0]  res_it16;
  logic [15:0] res_cyc16;
  logic        res_valid16, res_ready16, busy16;

`ifdef SYNDROME_STREAM_STATS_EN
  logic [31:0] stat_frames8, stat_frames16;
  logic [15:0] stat_max8, stat_max16;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  syndrome_stream_driver #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(5), .STREAM_WIDTH(8)
  ) u_dut8 (
    .clk(clk), .reset(reset),
    .frame_data(frame_data8), .frame_valid(frame_valid8), .frame_ready(frame_ready8),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
    .result_iterations(res_it8), .result_cycles(res_cyc8),
    .result_valid(res_valid8), .result_ready(res_ready8),
    .busy(busy8)
`ifdef SYNDROME_STREAM_STATS_EN
    , .stat_frames(stat_frames8), .stat_max_cycles(stat_max8)
`endif
  );

  syndrome_stream_driver #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(5), .STREAM_WIDTH(16)
  ) u_dut16 (
    .clk(clk), .reset(reset),
    .frame_data(frame_data16), .frame_valid(frame_valid16), .frame_ready(frame_ready16),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ready(rx_ready16),
    .result_iterations(res_it16), .result_cycles(res_cyc16),
    .result_valid(res_valid16), .result_ready(res_ready16),
    .busy(busy16)
`ifdef SYNDROME_STREAM_STATS_EN
    , .stat_frames(stat_frames16), .stat_max_cycles(stat_max16)
`endif
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Header plus five data bytes on consecutive cycles with tx_ready held high.
  task automatic stream8(input logic [39:0] frame, input string tag);
    logic [7:0] exp_b;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) exp_b = HDR_MSG;
      else        exp_b = frame[8*(i-1) +: 8];
      check($sformatf("%s_valid%0d", tag, i), 40'(tx_valid8), 40'd1);
      check($sformatf("%s_beat%0d", tag, i), 40'(tx_data8), 40'(exp_b));
      step();
    end
    check($sformatf("%s_end_valid", tag), 40'(tx_valid8), 40'd0);
    check($sformatf("%s_rx_ready", tag), 40'(rx_ready8), 40'd1);
  endtask

  // Feed a 3-byte reply, hold the result unacknowledged, then accept it.
  task automatic decode8(input logic [7:0] it, input logic [15:0] cyc, input string tag);
    rx_valid8 = 1'b1;
    rx_data8  = it;
    step();
    rx_data8 = cyc[15:8];
    step();
    rx_data8 = cyc[7:0];
    step();
    rx_valid8 = 1'b0;
    rx_data8  = 8'h00;
    check($sformatf("%s_iter", tag), 40'(res_it8), 40'(it));
    check($sformatf("%s_cycles", tag), 40'(res_cyc8), 40'(cyc));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_hold_valid%0d", tag, i), 40'(res_valid8), 40'd1);
      check($sformatf("%s_hold_fready%0d", tag, i), 40'(frame_ready8), 40'd0);
      step();
    end
    res_ready8 = 1'b1;
    step();
    res_ready8 = 1'b0;
    check($sformatf("%s_valid_clr", tag), 40'(res_valid8), 40'd0);
    check($sformatf("%s_fready_back", tag), 40'(frame_ready8), 40'd1);
    check($sformatf("%s_busy_low", tag), 40'(busy8), 40'd0);
    check($sformatf("%s_cycles_kept", tag), 40'(res_cyc8), 40'(cyc));
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp16 [4];
    int k;
    exp16[0] = 16'h0002;
    exp16[1] = 16'h4455;
    exp16[2] = 16'h2233;
    exp16[3] = 16'h0011;

    reset = 1'b0;
    frame_data8 = '0;  frame_valid8 = 1'b0;  tx_ready8 = 1'b0;
    rx_data8 = '0;     rx_valid8 = 1'b0;     res_ready8 = 1'b0;
    frame_data16 = '0; frame_valid16 = 1'b0; tx_ready16 = 1'b0;
    rx_data16 = '0;    rx_valid16 = 1'b0;    res_ready16 = 1'b0;
    step();
    step();

    // Reset state
    check("rst_tx_valid", 40'(tx_valid8), 40'd0);
    check("rst_tx_data", 40'(tx_data8), 40'd0);
    check("rst_frame_ready", 40'(frame_ready8), 40'd0);
    check("rst_rx_ready", 40'(rx_ready8), 40'd0);
    check("rst_busy", 40'(busy8), 40'd0);
    check("rst_result_valid", 40'(res_valid8), 40'd0);
    check("rst_tx_valid16", 40'(tx_valid16), 40'd0);

    // Test 1: start message sent exactly once after reset release
    tx_ready8 = 1'b1;
    reset = 1'b1;
    step();
    check("start_valid", 40'(tx_valid8), 40'd1);
    check("start_data", 40'(tx_data8), 40'(START_MSG));
    check("start_busy", 40'(busy8), 40'd1);
    check("start_fready", 40'(frame_ready8), 40'd0);
    step();
    check("start_done_valid", 40'(tx_valid8), 40'd0);
    check("idle_busy", 40'(busy8), 40'd0);
    check("idle_fready", 40'(frame_ready8), 40'd1);
    step();
    check("start_once", 40'(tx_valid8), 40'd0);
    check("start16_held_valid", 40'(tx_valid16), 40'd1);
    check("start16_held_data", 40'(tx_data16), 40'h0001);

    // Test 2: 8-bit stream, frame changed after acceptance must be ignored
    frame_data8  = 40'h11_2233_4455;
    frame_valid8 = 1'b1;
    step();
    frame_valid8 = 1'b0;
    frame_data8  = 40'hFF_FFFF_FFFF;
    check("t2_fready_low", 40'(frame_ready8), 40'd0);
    stream8(40'h11_2233_4455, "t2");

    // Test 4: reply 03 00 2A -> 3 iterations, 42 cycles
    decode8(8'h03, 16'd42, "t4");
`ifdef SYNDROME_STREAM_STATS_EN
    check("stat_frames_1", 40'(stat_frames8), 40'd1);
    check("stat_max_1", 40'(stat_max8), 40'd42);
`endif

    // Test 6: second decode with a smaller cycle count
    frame_data8  = 40'hA1_B2C3_D4E5;
    frame_valid8 = 1'b1;
    step();
    frame_valid8 = 1'b0;
    stream8(40'hA1_B2C3_D4E5, "t6");
    decode8(8'h05, 16'd17, "t6");
`ifdef SYNDROME_STREAM_STATS_EN
    check("stat_frames_2", 40'(stat_frames8), 40'd2);
    check("stat_max_2", 40'(stat_max8), 40'd42);
`endif

    // Test 3: 16-bit stream with tx_ready toggling
    tx_ready16 = 1'b1;
    step();
    tx_ready16 = 1'b0;
    check("t3_start_done", 40'(tx_valid16), 40'd0);
    check("t3_fready", 40'(frame_ready16), 40'd1);
    frame_data16  = 40'h11_2233_4455;
    frame_valid16 = 1'b1;
    step();
    frame_valid16 = 1'b0;
    frame_data16  = 40'h0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      tx_ready16 = ((cyc % 2) == 0);
      check($sformatf("t3_valid_c%0d", cyc), 40'(tx_valid16), 40'd1);
      if (tx_valid16 && tx_ready16) begin
        check($sformatf("t3_beat%0d", k), 40'(tx_data16), 40'(exp16[k]));
        k++;
      end
      step();
    end
    tx_ready16 = 1'b0;
    check("t3_beat_count", 40'(k), 40'd4);
    check("t3_end_valid", 40'(tx_valid16), 40'd0);
    check("t3_rx_ready", 40'(rx_ready16), 40'd1);

    // Test 5: reset in the middle of a frame
    frame_data8  = 40'h01_0203_0405;
    frame_valid8 = 1'b1;
    step();
    frame_valid8 = 1'b0;
    step();
    step();
    step();
    check("t5_pre_reset_beat", 40'(tx_data8), 40'h03);
    reset = 1'b0;
    #1;
    check("t5_rst_tx_valid", 40'(tx_valid8), 40'd0);
    check("t5_rst_tx_data", 40'(tx_data8), 40'd0);
    check("t5_rst_busy", 40'(busy8), 40'd0);
    check("t5_rst_fready", 40'(frame_ready8), 40'd0);
    check("t5_rst_rx_ready", 40'(rx_ready8), 40'd0);
    check("t5_rst_res_valid", 40'(res_valid8), 40'd0);
    check("t5_rst_res_cycles", 40'(res_cyc8), 40'd0);
`ifdef SYNDROME_STREAM_STATS_EN
    check("t5_rst_stat_frames", 40'(stat_frames8), 40'd0);
    check("t5_rst_stat_max", 40'(stat_max8), 40'd0);
`endif
    step();
    reset = 1'b1;
    step();
    check("t5_start_valid", 40'(tx_valid8), 40'd1);
    check("t5_start_data", 40'(tx_data8), 40'(START_MSG));
    step();
    check("t5_idle_fready", 40'(frame_ready8), 40'd1);
    frame_valid8 = 1'b1;
    step();
    frame_valid8 = 1'b0;
    stream8(40'h01_0203_0405, "t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
